// File: rtl/maj_chain_eval.sv
// Majority-gate chain evaluator: folds a stream of gate descriptors into one result per chain.
// Optional macro MAJ_CHAIN_PARITY_EN adds out_parity, the XOR of every intermediate chain value.
module maj_chain_eval #(
   parameter int MAX_DEPTH = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_a,
   input  logic       in_b,
   input  logic       in_c,
   input  logic       in_na,
   input  logic       in_nb,
   input  logic       in_nw,
   input  logic       in_first,
   input  logic       in_last,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_value,
   output logic [7:0] out_depth,
   output logic       out_err
`ifdef MAJ_CHAIN_PARITY_EN
   ,
   output logic       out_parity
`endif
);

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   localparam logic [7:0] MAX_D = 8'(MAX_DEPTH);

   state_t     state, state_nx;
   logic       w, w_nx;
   logic [7:0] depth, depth_nx;
   logic       err, err_nx;
   logic       out_value_nx;
   logic [7:0] out_depth_nx;
   logic       out_err_nx;
   logic       op_a, op_b, beat, in_chain;
`ifdef MAJ_CHAIN_PARITY_EN
   logic       par, par_nx, out_parity_nx;
`endif

   function automatic logic maj(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

   assign in_ready  = (state != HOLD);
   assign out_valid = (state == HOLD);
   assign op_a      = in_a ^ in_na;
   assign op_b      = in_b ^ in_nb;
   assign beat      = in_valid & in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         w         <= 1'b0;
         depth     <= 8'd0;
         err       <= 1'b0;
         out_value <= 1'b0;
         out_depth <= 8'd0;
         out_err   <= 1'b0;
`ifdef MAJ_CHAIN_PARITY_EN
         par        <= 1'b0;
         out_parity <= 1'b0;
`endif
      end else begin
         state     <= state_nx;
         w         <= w_nx;
         depth     <= depth_nx;
         err       <= err_nx;
         out_value <= out_value_nx;
         out_depth <= out_depth_nx;
         out_err   <= out_err_nx;
`ifdef MAJ_CHAIN_PARITY_EN
         par        <= par_nx;
         out_parity <= out_parity_nx;
`endif
      end
   end

   // Result registers load only on the closing beat so they stay frozen through HOLD.
   always_comb begin
      state_nx     = state;
      w_nx         = w;
      depth_nx     = depth;
      err_nx       = err;
      out_value_nx = out_value;
      out_depth_nx = out_depth;
      out_err_nx   = out_err;
      in_chain     = 1'b0;
`ifdef MAJ_CHAIN_PARITY_EN
      par_nx        = par;
      out_parity_nx = out_parity;
`endif
      case (state)
         IDLE, ACCUM: begin
            if (beat) begin
               if (in_first) begin
                  in_chain = 1'b1;
                  w_nx     = maj(op_a, op_b, in_c);
                  depth_nx = 8'd1;
                  if (state == ACCUM) err_nx = 1'b1;
`ifdef MAJ_CHAIN_PARITY_EN
                  par_nx = w_nx;
`endif
               end else if (state == ACCUM) begin
                  in_chain = 1'b1;
                  w_nx     = maj(op_a, op_b, w ^ in_nw);
                  if (depth >= MAX_D) begin
                     depth_nx = MAX_D;
                     err_nx   = 1'b1;
                  end else begin
                     depth_nx = depth + 8'd1;
                  end
`ifdef MAJ_CHAIN_PARITY_EN
                  par_nx = par ^ w_nx;
`endif
               end else begin
                  err_nx = 1'b1;
               end
               if (in_chain) begin
                  if (in_last) begin
                     state_nx     = HOLD;
                     out_value_nx = w_nx;
                     out_depth_nx = depth_nx;
                     out_err_nx   = err_nx;
`ifdef MAJ_CHAIN_PARITY_EN
                     out_parity_nx = par_nx;
`endif
                  end else begin
                     state_nx = ACCUM;
                  end
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_nx = IDLE;
               err_nx   = 1'b0;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_maj_chain_eval.sv
// Randomized bench for maj_chain_eval against a chain-level reference model.
// Runs a default-depth instance and a MAX_DEPTH=4 instance side by side on the same stimulus.
module tb_maj_chain_eval;

   logic clk = 1'b0;
   logic rst;
   logic in_valid, in_a, in_b, in_c, in_na, in_nb, in_nw, in_first, in_last, out_ready;
   logic rdy0, vld0, val0, err0;
   logic rdy4, vld4, val4, err4;
   logic [7:0] dep0, dep4;
`ifdef MAJ_CHAIN_PARITY_EN
   logic par0, par4;
`endif

   always #5 clk = ~clk;

   maj_chain_eval u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
      .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_na(in_na), .in_nb(in_nb), .in_nw(in_nw),
      .in_first(in_first), .in_last(in_last), .out_valid(vld0), .out_ready(out_ready),
      .out_value(val0), .out_depth(dep0), .out_err(err0)
`ifdef MAJ_CHAIN_PARITY_EN
      , .out_parity(par0)
`endif
   );

   maj_chain_eval #(.MAX_DEPTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4),
      .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_na(in_na), .in_nb(in_nb), .in_nw(in_nw),
      .in_first(in_first), .in_last(in_last), .out_valid(vld4), .out_ready(out_ready),
      .out_value(val4), .out_depth(dep4), .out_err(err4)
`ifdef MAJ_CHAIN_PARITY_EN
      , .out_parity(par4)
`endif
   );

   int total = 0;
   int bad = 0;

   // Reference model: the chain is kept as a list of effective operands and folded at its end.
   bit m_in_chain, m_err, m_c;
   int m_n;
   bit ma[0:63], mb[0:63], mnw[0:63];
   int exp_val, exp_par, exp_dep0, exp_err0, exp_dep4, exp_err4;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic int maj(input int x, input int y, input int z);
      return ((x + y + z) >= 2) ? 1 : 0;
   endfunction

   function automatic void model_eval();
      int w;
      w = maj(ma[0], mb[0], m_c);
      exp_par = w;
      for (int i = 1; i < m_n; i++) begin
         w = maj(ma[i], mb[i], w ^ mnw[i]);
         exp_par ^= w;
      end
      exp_val  = w;
      exp_dep0 = (m_n > 64) ? 64 : m_n;
      exp_err0 = (m_err || m_n > 64) ? 1 : 0;
      exp_dep4 = (m_n > 4) ? 4 : m_n;
      exp_err4 = (m_err || m_n > 4) ? 1 : 0;
   endfunction

   task automatic applyStimulus(input bit first, input bit last, input bit a, input bit b,
                                input bit c, input bit na, input bit nb, input bit nw);
      @(negedge clk);
      checkOutput("in_ready_before_beat", {31'd0, rdy0}, 32'd1);
      in_valid = 1'b1; in_first = first; in_last = last;
      in_a = a; in_b = b; in_c = c; in_na = na; in_nb = nb; in_nw = nw;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (first) begin
         if (m_in_chain) m_err = 1'b1;
         m_in_chain = 1'b1;
         m_n = 0;
         m_c = c;
      end else if (!m_in_chain) begin
         m_err = 1'b1;
      end
      if (m_in_chain) begin
         ma[m_n] = a ^ na; mb[m_n] = b ^ nb; mnw[m_n] = nw;
         m_n++;
         if (last) begin
            model_eval();
            m_in_chain = 1'b0;
         end
      end
   endtask

   task automatic checkStable(input string tag);
      checkOutput({tag, "_valid"},  {31'd0, vld0}, 32'd1);
      checkOutput({tag, "_value"},  {31'd0, val0}, exp_val);
      checkOutput({tag, "_depth"},  {24'd0, dep0}, exp_dep0);
      checkOutput({tag, "_err"},    {31'd0, err0}, exp_err0);
      checkOutput({tag, "_valid4"}, {31'd0, vld4}, 32'd1);
      checkOutput({tag, "_value4"}, {31'd0, val4}, exp_val);
      checkOutput({tag, "_depth4"}, {24'd0, dep4}, exp_dep4);
      checkOutput({tag, "_err4"},   {31'd0, err4}, exp_err4);
      checkOutput({tag, "_ready"},  {31'd0, rdy0}, 32'd0);
`ifdef MAJ_CHAIN_PARITY_EN
      checkOutput({tag, "_parity"},  {31'd0, par0}, exp_par);
      checkOutput({tag, "_parity4"}, {31'd0, par4}, exp_par);
`endif
   endtask

   // Called #1 after the closing beat: checks the result, stalls, then completes the handshake.
   task automatic checkResult(input int hold);
      checkStable("result");
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1;
         in_a = ~val0; in_b = ~val0; in_c = 1'b0; in_na = 1'b0; in_nb = 1'b0;
         @(posedge clk);
         #1;
         checkStable("hold");
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      m_err = 1'b0;
      checkOutput("handshake_valid",  {31'd0, vld0}, 32'd0);
      checkOutput("handshake_valid4", {31'd0, vld4}, 32'd0);
      checkOutput("handshake_ready",  {31'd0, rdy0}, 32'd1);
   endtask

   task automatic run_chain(input int len, input bit allow_restart);
      bit first;
      for (int i = 0; i < len; i++) begin
         first = (i == 0) || (allow_restart && $urandom_range(0, 9) == 0);
         applyStimulus(first, i == len - 1, 1'($urandom), 1'($urandom), 1'($urandom),
                       1'($urandom), 1'($urandom), 1'($urandom));
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_a = 0; in_b = 0; in_c = 0; in_na = 0; in_nb = 0; in_nw = 0; in_first = 0; in_last = 0;
      m_in_chain = 0; m_err = 0; m_n = 0; m_c = 0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_valid", {31'd0, vld0}, 32'd0);
      checkOutput("reset_value", {31'd0, val0}, 32'd0);
      checkOutput("reset_depth", {24'd0, dep0}, 32'd0);
      checkOutput("reset_err",   {31'd0, err0}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("post_reset_ready", {31'd0, rdy0}, 32'd1);

      // Six-beat reference chain; the depth-4 instance saturates and flags it.
      applyStimulus(1, 0, 1, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 1, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 1, 0, 1, 0, 1);
      applyStimulus(0, 0, 0, 1, 0, 1, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
      checkOutput("six_value",  {31'd0, val0}, 32'd0);
      checkOutput("six_depth",  {24'd0, dep0}, 32'd6);
      checkOutput("six_err",    {31'd0, err0}, 32'd0);
      checkOutput("six_depth4", {24'd0, dep4}, 32'd4);
      checkOutput("six_err4",   {31'd0, err4}, 32'd1);
      checkOutput("six_value4", {31'd0, val4}, 32'd0);
`ifdef MAJ_CHAIN_PARITY_EN
      checkOutput("six_parity", {31'd0, par0}, 32'd1);
`endif
      checkResult(5);

      // Single-beat chain.
      applyStimulus(1, 1, 1, 1, 0, 0, 0, 0);
      checkOutput("single_value", {31'd0, val0}, 32'd1);
      checkOutput("single_depth", {24'd0, dep0}, 32'd1);
      checkOutput("single_err",   {31'd0, err0}, 32'd0);
      checkResult(1);

      // Stray beat in IDLE, then a clean two-beat chain reports the sticky error.
      applyStimulus(0, 0, 1, 1, 1, 0, 0, 0);
      applyStimulus(1, 0, 1, 1, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 1, 0, 0, 1);
      checkOutput("stray_value", {31'd0, val0}, 32'd0);
      checkOutput("stray_depth", {24'd0, dep0}, 32'd2);
      checkOutput("stray_err",   {31'd0, err0}, 32'd1);
      checkResult(0);

      // Reset at the third beat discards the chain without any output.
      applyStimulus(1, 0, 1, 1, 1, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 1, 0, 0, 0);
      @(negedge clk);
      in_valid = 1'b1; in_first = 1'b0; in_last = 1'b1; in_a = 1'b1; in_b = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      checkOutput("midrst_valid", {31'd0, vld0}, 32'd0);
      checkOutput("midrst_ready", {31'd0, rdy0}, 32'd1);
      checkOutput("midrst_depth", {24'd0, dep0}, 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b0;
      m_in_chain = 0; m_err = 0; m_n = 0;
      repeat (2) begin
         @(posedge clk);
         #1;
         checkOutput("after_rst_valid", {31'd0, vld0}, 32'd0);
         checkOutput("after_rst_ready", {31'd0, rdy0}, 32'd1);
      end
      run_chain(3, 0);
      checkResult(0);

      // Randomized chains with stray beats and restarts.
      for (int it = 0; it < 80; it++) begin
         if ($urandom_range(0, 5) == 0)
            applyStimulus(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom), 1'($urandom), 1'($urandom));
         run_chain($urandom_range(1, 8), 1);
         checkResult($urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/maj_chain_eval.md
MAJ_CHAIN_EVAL -- requirements
Module: maj_chain_eval

Interface
REQ-001 SHALL have parameter MAX_DEPTH, default 64, maximum number of gates per chain (range 2..255).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  gate descriptor beat is valid.
REQ-005 SHALL have port in_ready  output  1  block accepts a beat (transfer = in_valid & in_ready).
REQ-006 SHALL have ports in_a, in_b, in_c  input  1 each  gate operands (in_c is used only on the first beat).
REQ-007 SHALL have ports in_na, in_nb, in_nw  input  1 each  complement flags for a, b and the chain value.
REQ-008 SHALL have ports in_first, in_last  input  1 each  chain start and chain end markers.
REQ-009 SHALL have port out_valid  output  1  result is valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port out_value  output  1  final chain value.
REQ-012 SHALL have port out_depth  output  8  number of gates evaluated.
REQ-013 SHALL have port out_err  output  1  a protocol or depth error occurred in this chain.

Function
REQ-014 SHALL implement states IDLE, ACCUM and HOLD.
REQ-015 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in HOLD.
REQ-016 A first beat (in_first=1) SHALL set w = MAJ(a^na, b^nb, c) and depth = 1, then go to ACCUM (in_nw is ignored).
REQ-017 An ACCUM beat with in_first=0 SHALL set w = MAJ(a^na, b^nb, w^nw) and depth = depth+1.
REQ-018 A beat with in_last=1 SHALL go to HOLD; out_valid SHALL rise in the next cycle with out_value = the final w (latency 1).
REQ-019 A beat with in_first=1 and in_last=1 SHALL produce depth 1 and out_value = MAJ(a^na, b^nb, c).
REQ-020 In HOLD, outputs SHALL stay stable until out_valid & out_ready; the block SHALL then return to IDLE and deassert out_valid in the same edge.
REQ-021 An IDLE beat with in_first=0 SHALL be accepted and discarded, and SHALL set a sticky error that is reported on the next result's out_err.
REQ-022 in_first=1 in ACCUM SHALL restart the chain: the partial chain is dropped, depth = 1, and the error flag is set.
REQ-023 A beat that would make depth exceed MAX_DEPTH SHALL be evaluated normally, depth SHALL saturate at MAX_DEPTH, and the error flag SHALL be set.
REQ-024 The error flag SHALL clear when the result handshake completes.
REQ-025 out_value, out_depth and out_err SHALL be driven from registers only.

Reset
REQ-026 Asserting rst SHALL immediately force IDLE: out_valid=0, out_value=0, out_depth=0, out_err=0, w=0, depth=0, error flag cleared.
REQ-027 Asserting rst mid-chain or in HOLD SHALL discard the chain and the pending result without emitting any output.
REQ-028 in_ready SHALL read 1 from the first edge after rst deasserts.

Configuration
REQ-029 With macro MAJ_CHAIN_PARITY_EN defined, the block SHALL add output out_parity (1 bit) = XOR of every intermediate w of the chain, including the final one.
REQ-030 out_parity SHALL be registered alongside out_value, shall reset to 0, and shall restart on a first beat.
REQ-031 Without MAJ_CHAIN_PARITY_EN, the port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-032 Six-beat chain: first (a=1,b=0,c=1); (0,0); (1,1); (na=1,a=1,b=1,nw=1); (na=1,a=0,b=1); last (0,0) -> out_value=0, out_depth=6, out_err=0, out_parity=1.
REQ-033 Single beat with first=1, last=1, a=1, b=1, c=0 -> one cycle later out_value=1, out_depth=1, out_err=0.
REQ-034 Hold out_ready=0 for 5 cycles after a result -> out_valid and outputs stay stable, in_ready=0, and no beats are accepted.
REQ-035 Beat without first in IDLE, then a valid 2-beat chain -> result is correct, with out_depth=2 and out_err=1.
REQ-036 MAX_DEPTH=4 with a 6-beat chain -> out_depth=4, out_err=1, and out_value reflects all 6 gates.
REQ-037 Assert rst at beat 3 of a chain -> out_valid stays 0, in_ready=1 after release, and the next chain evaluates correctly.
